// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial framer driving a single registered line.
// Frame layout on d: start (0), DATA_W data bits LSB first, optional even
// parity, stop (1). Each bit is held for BIT_CYCLES clocks.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle at 1, ready for a word
// S_START | start bit (0) on the line
// S_DATA  | data bits, shift register LSB on the line
// S_PAR   | even parity of the captured word (PARITY_EN=1 only)
// S_STOP  | stop bit (1); last cycle may accept the next word
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              d,
  output logic              busy,
  output logic              frame_done
);

  localparam int          BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]  CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [7:0]        cyc_cnt, cyc_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              par_q, par_n;
  logic              d_n, busy_n, done_n;
  logic              last_cyc;
  logic              accept;

  // Handshake and bit-period terminal count come straight from current state.
  always_comb begin
    last_cyc = (cyc_cnt == CYC_LAST);
    tx_ready = (state == S_IDLE) || ((state == S_STOP) && last_cyc);
    accept   = tx_valid && tx_ready;
  end

  // Next-state logic; line level is computed for the state being entered so
  // that d, busy and frame_done can be registered without extra latency.
  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    par_n   = par_q;
    d_n     = d;

    case (state)
      S_IDLE: begin
        d_n = 1'b1;
        if (accept) begin
          state_n = S_START;
          cyc_n   = 8'd0;
          bit_n   = '0;
          shift_n = tx_data;
          par_n   = ^tx_data;
          d_n     = 1'b0;
        end
      end

      S_START: begin
        if (last_cyc) begin
          state_n = S_DATA;
          cyc_n   = 8'd0;
          bit_n   = '0;
          d_n     = shift_q[0];
        end else begin
          cyc_n = cyc_cnt + 8'd1;
        end
      end

      S_DATA: begin
        if (last_cyc) begin
          cyc_n = 8'd0;
          if (bit_cnt == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_n = S_PAR;
              d_n     = par_q;
            end else begin
              state_n = S_STOP;
              d_n     = 1'b1;
            end
          end else begin
            bit_n   = bit_cnt + BIT_W'(1);
            shift_n = shift_q >> 1;
            d_n     = shift_n[0];
          end
        end else begin
          cyc_n = cyc_cnt + 8'd1;
        end
      end

      S_PAR: begin
        if (last_cyc) begin
          state_n = S_STOP;
          cyc_n   = 8'd0;
          d_n     = 1'b1;
        end else begin
          cyc_n = cyc_cnt + 8'd1;
        end
      end

      S_STOP: begin
        if (last_cyc) begin
          cyc_n = 8'd0;
          if (accept) begin
            // Back-to-back: straight into the next start bit, no idle gap.
            state_n = S_START;
            bit_n   = '0;
            shift_n = tx_data;
            par_n   = ^tx_data;
            d_n     = 1'b0;
          end else begin
            state_n = S_IDLE;
            d_n     = 1'b1;
          end
        end else begin
          cyc_n = cyc_cnt + 8'd1;
        end
      end

      default: begin
        state_n = S_IDLE;
        cyc_n   = 8'd0;
        bit_n   = '0;
        d_n     = 1'b1;
      end
    endcase

    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_STOP) && (cyc_n == CYC_LAST);
  end

  // State, counters, datapath and registered line outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cyc_cnt    <= 8'd0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      d          <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cyc_cnt    <= cyc_n;
      bit_cnt    <= bit_n;
      shift_q    <= shift_n;
      par_q      <= par_n;
      d          <= d_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter that drives a single-bit line `d`.
- A positive-edge D flip-flop receiver samples `d` once per bit period.
- Takes a DATA_W-bit word through a valid/ready handshake and emits a framed bit stream: start bit, data LSB first, optional even parity, stop bit.
- It is the transmitting end of the serial data path that our posedge capture flip-flops terminate.

Parameters:
- DATA_W, 8: width of the parallel data word; legal range 1..32.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
- BIT_CYCLES, 1: clock cycles each bit is held on `d`; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_data  input  DATA_W  word to transmit; sampled only on the accepting edge.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  transmitter can accept a word this cycle.
- d  output  1  serial line; registered; idle level is 1.
- busy  output  1  high while a frame is on the line (START through STOP).
- frame_done  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset:
  - rst_n is sampled low at a rising edge of clk.
  - Next state is IDLE: d=1, busy=0, frame_done=0, tx_ready=1, bit and cycle counters cleared, shift register cleared.
  - Reset mid-frame aborts the frame immediately; the next cycle shows d=1 and no frame_done.
- States and transitions:
  - IDLE -> START -> DATA -> PARITY (only when PARITY_EN=1) -> STOP -> IDLE, or STOP -> START when back-to-back.
- Handshake:
  - A transfer occurs at a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready=1 in IDLE, and in the last cycle of STOP; 0 otherwise.
  - tx_ready is combinational from state and counters.
  - tx_valid while tx_ready=0 is ignored; tx_data is not sampled and no word is lost or queued.
- Latency:
  - The start bit (d=0) appears on d in the cycle immediately after the accepting edge.
- Bit timing:
  - Each bit is held for exactly BIT_CYCLES consecutive cycles.
  - A cycle counter runs 0..BIT_CYCLES-1, and the bit advances when it reaches BIT_CYCLES-1.
- DATA:
  - Bit i (i = 0..DATA_W-1) is tx_data[i] as captured at acceptance, LSB first.
  - The captured word is shifted right internally.
  - Later changes on tx_data have no effect on the frame in flight.
- PARITY:
  - d = XOR of all captured data bits, so the total number of 1s across data and parity is even.
- STOP:
  - d=1 for BIT_CYCLES cycles.
  - frame_done=1 only in the last cycle of STOP.
- Back-to-back:
  - If a transfer occurs in the last STOP cycle, the next cycle is START with the new word; there is no idle gap.
  - busy stays 1 across the boundary, and frame_done still pulses for the finished frame.
- Frame length: (DATA_W + 2 + PARITY_EN) * BIT_CYCLES cycles.
- busy is 1 in all non-IDLE states.
- d, busy and frame_done are driven from flops, so there are no combinational glitches.
- The `d` output feeds a posedge DFF on the same clk. Setup to that capture edge is one full cycle.

Test Plan:
- Default parameters, reset released, idle 3 cycles -> d=1, tx_ready=1, busy=0 throughout.
- Send tx_data=0xA5 with PARITY_EN=1, BIT_CYCLES=1:
  - d sequence from the cycle after acceptance is 0,1,0,1,0,0,1,0,1,0,1 (parity 0).
  - frame_done high on cycle 11 only.
  - tx_ready returns 1 on cycle 11.
- Send 0x07, then hold tx_valid=1 with 0x80 ready for the final STOP cycle:
  - First frame d = 0,1,1,1,0,0,0,0,0,1,1 (parity 1).
  - Next cycle starts 0x80's start bit with no idle gap; busy never drops.
- BIT_CYCLES=3, PARITY_EN=0, send 0x01:
  - d = 0 for 3 cycles, 1 for 3 cycles, then 0 for 21 cycles, then stop 1 for 3 cycles (30 cycles total).
  - Toggling tx_valid and tx_data during the frame has no effect.
- Assert rst_n=0 for one edge at the 5th data bit of 0xFF:
  - Next cycle d=1, busy=0, tx_ready=1, frame_done never pulses.
  - A fresh 0x3C sent afterwards transmits correctly.
- Drive `d` into a posedge DFF on clk and shift the captured bits into a reference register:
  - For 256 sequential words 0x00..0xFF, the recovered data and parity match the word sent.
